axi_burst_former: RTL

Parametrised AXI4 write-path former. It gathers a stream of data beats and a stream of burst descriptors (address plus length) from an upstream producer, such as the JPEG pixel writer, and issues them as AXI4 AW and W bursts. It also tracks B responses so that "empty" means the writes are complete, not just dispatched. It sits between the decoder output stage and the memory-side AXI interconnect. It generalises the fixed 32-bit, 3-bit-length former with configurable widths, depths and outstanding-write limit, byte strobes, and error capture.

---
 rtl/axi_burst_former_pkg.sv | 16 +
 rtl/fifo_v3.sv | 70 +++++++
 rtl/axi_burst_former.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/axi_burst_former_pkg.sv
// Shared AXI4 encodings and helpers for the write-path burst former.
package axi_burst_former_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AxSIZE encoding: log2 of the number of bytes per beat.
  function automatic logic [2:0] size_from_width(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with optional fall-through and a synchronous flush.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  is_empty;
  logic                  bypass;
  logic                  do_push;
  logic                  do_pop;

  assign is_empty = (count == '0);
  assign full_o   = (count == CNT_W'(DEPTH));
  // In fall-through mode a push into an empty FIFO popped in the same cycle never touches storage.
  assign bypass   = FALL_THROUGH && is_empty && push_i && pop_i;
  assign do_push  = push_i && !full_o && !bypass;
  assign do_pop   = pop_i && !is_empty;

  // NOTE: every signal written in always_comb is given a default first, so no path can infer a latch.
  always_comb begin
    empty_o = is_empty;
    data_o  = mem[rd_ptr];
    if (FALL_THROUGH && is_empty && push_i) begin
      empty_o = 1'b0;
      data_o  = data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/axi_burst_former.sv
// Turns a beat stream plus {addr,len} descriptors into AXI4 AW/W bursts and retires B responses.
module axi_burst_former
  import axi_burst_former_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned LEN_W           = 8,
  parameter int unsigned ADDR_DEPTH      = 2,
  parameter int unsigned DATA_DEPTH      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  output logic                  empty_o,
  output logic                  err_o,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [DATA_W/8-1:0]   strb_i,
  input  logic                  addr_valid_i,
  output logic                  addr_ready_o,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ADDR_W-1:0]     awaddr_o,
  output logic [7:0]            awlen_o,
  output logic [2:0]            awsize_o,
  output logic [1:0]            awburst_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  output logic                  wlast_o,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  input  logic [1:0]            bresp_i
);

  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam int unsigned OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DESC_W    = LEN_W + ADDR_W;
  localparam int unsigned BEAT_W    = STRB_W + DATA_W;
  localparam int unsigned LEN_DEPTH = 2;
  localparam logic [2:0]  AW_SIZE   = size_from_width(DATA_W);

  logic              desc_full, desc_empty, desc_push;
  logic [DESC_W-1:0] desc_q;
  logic [LEN_W-1:0]  desc_len;

  logic              beat_full, beat_empty, beat_push;
  logic [BEAT_W-1:0] beat_q;

  logic              len_full, len_empty;
  logic [LEN_W-1:0]  len_head;

  logic              aw_hs, w_hs, w_done, b_retire;
  logic [OUT_W-1:0]  outstanding;
  logic [LEN_W-1:0]  beat_cnt;

  // Descriptor path: {len, addr}.
  assign addr_ready_o = !desc_full;
  assign desc_push    = addr_valid_i && addr_ready_o;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (DESC_W),
    .DEPTH        (ADDR_DEPTH)
  ) i_desc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .full_o  (desc_full),
    .empty_o (desc_empty),
    .data_i  ({len_i, addr_i}),
    .push_i  (desc_push),
    .data_o  (desc_q),
    .pop_i   (aw_hs)
  );

  assign desc_len  = desc_q[DESC_W-1:ADDR_W];
  assign awaddr_o  = desc_q[ADDR_W-1:0];
  assign awlen_o   = 8'(desc_len);
  assign awsize_o  = AW_SIZE;
  assign awburst_o = AXI_BURST_INCR;

  // An AW may only issue when its length has somewhere to wait for the matching W beats.
  assign awvalid_o = !desc_empty && !len_full && (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign aw_hs     = awvalid_o && awready_i;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (LEN_W),
    .DEPTH        (LEN_DEPTH)
  ) i_len_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .full_o  (len_full),
    .empty_o (len_empty),
    .data_i  (desc_len),
    .push_i  (aw_hs),
    .data_o  (len_head),
    .pop_i   (w_done)
  );

  // Beat path: {strb, data}.
  assign data_ready_o = !beat_full;
  assign beat_push    = data_valid_i && data_ready_o;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (BEAT_W),
    .DEPTH        (DATA_DEPTH)
  ) i_beat_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .full_o  (beat_full),
    .empty_o (beat_empty),
    .data_i  ({strb_i, data_i}),
    .push_i  (beat_push),
    .data_o  (beat_q),
    .pop_i   (w_hs)
  );

  // W beats are gated by the length FIFO, so they can never overtake their AW.
  assign wvalid_o = !beat_empty && !len_empty;
  assign wdata_o  = beat_q[DATA_W-1:0];
  assign wstrb_o  = beat_q[BEAT_W-1:DATA_W];
  assign wlast_o  = wvalid_o && (beat_cnt == len_head);
  assign w_hs     = wvalid_o && wready_i;
  assign w_done   = w_hs && wlast_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (flush_i) begin
      beat_cnt <= '0;
    end else if (w_hs) begin
      beat_cnt <= wlast_o ? '0 : beat_cnt + LEN_W'(1);
    end
  end

  // A B arriving with nothing outstanding is dropped so the counter cannot wrap.
  assign bready_o = 1'b1;
  assign b_retire = bvalid_i && bready_o && (outstanding != '0);

  // Flush deliberately leaves this alone: bursts already on the bus still owe a B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (aw_hs && !b_retire) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (!aw_hs && b_retire) begin
      outstanding <= outstanding - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (flush_i) begin
      err_o <= 1'b0;
    end else if (b_retire && (bresp_i != AXI_RESP_OKAY)) begin
      err_o <= 1'b1;
    end
  end

  assign empty_o = desc_empty && beat_empty && len_empty && (outstanding == '0);

endmodule
